param_reg_file: RTL
===================

Name: param_reg_file

Overview:
- Parametrised successor to the fixed 4+4 general register file.
- NUM_REGS registers of WIDTH bits, each an independently selectable load/clear/up-down counter with wrap or saturate mode and a sticky per-register wrap flag.
- Two registered read ports.
- Sits between MuxA (write data) and MuxC/ALU (read data) in the ALU system datapath; replaces the R/T banks.

Parameters:
- WIDTH, 8, register and data width in bits (>=2).
- NUM_REGS, 8, number of registers (2..32); register index 0 is the lowest r_sel bit.
- SATURATE, 0, 0 = inc/dec wrap modulo 2^WIDTH; 1 = inc clamps at all-ones, dec clamps at zero.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- I  in  WIDTH  write data
- fun_sel  in  2  00 clear, 01 load I, 10 decrement, 11 increment
- r_sel  in  NUM_REGS  one bit per register; 1 = apply fun_sel this cycle, 0 = hold
- o1_sel  in  SEL_W  read port 1 register index; SEL_W = max(1, clog2(NUM_REGS))
- o2_sel  in  SEL_W  read port 2 register index
- status_clr  in  1  clears all wrap flags
- O1  out  WIDTH  registered read data, port 1
- O2  out  WIDTH  registered read data, port 2
- wrap_flags  out  NUM_REGS  sticky per-register wrap/saturation event flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers = RESET_VAL.
  - O1 = O2 = 0.
  - wrap_flags = 0.
  - Held while low; first update on the first rising edge after release.
- Register update on each rising edge, for each register k with r_sel[k]=1:
  - Clear: reg = 0.
  - Load: reg = I.
  - Decrement: reg = reg - 1.
  - Increment: reg = reg + 1.
  - Registers with r_sel[k]=0 hold.
  - Any number of registers may update in the same cycle with the same function.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - SATURATE=0: all-ones +1 gives 0; 0 -1 gives all-ones.
  - SATURATE=1: all-ones +1 stays all-ones; 0 -1 stays 0.
- Wrap flags:
  - wrap_flags[k] sets on the edge where register k increments from all-ones or decrements from 0 (SATURATE=0: wrap; SATURATE=1: clamp attempt).
  - Sticky until cleared.
  - Cleared when status_clr=1, or when register k is cleared (fun_sel=00 with r_sel[k]=1).
  - Same-edge set and clear: set wins.
- Read ports:
  - O1/O2 are registered; on each edge they load the post-update value of the selected register (write-through).
  - A write and a read of the same register in one cycle returns the new value.
  - Latency: 1 edge from select change to O1/O2 change.
  - Both ports may select the same register.
  - Index >= NUM_REGS reads 0.
- No enable beyond r_sel; with r_sel all 0 only O1/O2 and status_clr act.
- Reset mid-operation: immediate asynchronous return to reset values; no partial update survives.

Decomposition:
- Shared package param_rf_pkg:
  - fun_sel encodings FS_CLR, FS_LOAD, FS_DEC, FS_INC.
  - SEL_W computation function.
- One natural sub-module, rf_cell: single WIDTH register with fun_sel, enable, SATURATE, and wrap-flag logic.
- Top level instantiates NUM_REGS rf_cell instances in a generate loop and adds the two read muxes.

Test Plan:
- Reset with rst_n low mid-cycle, defaults -> all regs 0, O1=O2=0, wrap_flags=0 immediately, before the next edge.
- Load I=8'hA5 with r_sel=8'b0000_0101, o1_sel=0, o2_sel=2 -> after one edge O1=O2=8'hA5; regs 1,3..7 remain 0.
- SATURATE=0: load 8'hFF into reg 3, then increment -> reg3=8'h00, wrap_flags[3]=1; apply status_clr -> flag 0 next edge; decrement -> 8'hFF with flag set again.
- SATURATE=1: reg 0 at 0, decrement twice -> stays 0, wrap_flags[0]=1; increment -> 1, flag remains 1 until status_clr.
- Simultaneous events: increment reg 5 from 8'h0F while o1_sel=5 -> O1=8'h10 after the same edge; status_clr together with a wrapping increment of reg 5 -> wrap_flags[5]=1.
- NUM_REGS=6, WIDTH=16: o2_sel=7 -> O2=16'h0000; clear of reg 4 with a pending flag -> wrap_flags[4]=0.

Source files
------------

// File: rtl/param_rf_pkg.sv
// Shared encodings and sizing helpers for the parametrised register file.
package param_rf_pkg;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    // Read-select width; a two-register file still needs one select bit.
    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_cell.sv
// One register: clear/load/inc/dec with wrap or saturate, plus a sticky wrap flag.
// d_o is the post-update value so read ports can capture it on the same edge.
module rf_cell
    import param_rf_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter int              SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [1:0]       fun_sel_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             status_clr_i,
    output logic [WIDTH-1:0] d_o,
    output logic             flag_o
);

    logic [WIDTH-1:0] val_q, val_d;
    logic             flag_q, flag_d;
    logic             at_max, at_min, wrap_evt;

    assign at_max   = (val_q == {WIDTH{1'b1}});
    assign at_min   = (val_q == '0);
    assign wrap_evt = en_i && (((fun_sel_i == FS_INC) && at_max) ||
                               ((fun_sel_i == FS_DEC) && at_min));

    always_comb begin
        val_d = val_q;
        if (en_i) begin
            case (fun_sel_i)
                FS_CLR:  val_d = '0;
                FS_LOAD: val_d = data_i;
                FS_DEC:  val_d = (SATURATE != 0 && at_min) ? val_q : val_q - 1'b1;
                FS_INC:  val_d = (SATURATE != 0 && at_max) ? val_q : val_q + 1'b1;
            endcase
        end
    end

    // A wrap event on the same edge as a clear request keeps the flag set.
    always_comb begin
        flag_d = flag_q;
        if (status_clr_i || (en_i && fun_sel_i == FS_CLR))
            flag_d = 1'b0;
        if (wrap_evt)
            flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= RESET_VAL;
            flag_q <= 1'b0;
        end else begin
            val_q  <= val_d;
            flag_q <= flag_d;
        end
    end

    assign d_o    = val_d;
    assign flag_o = flag_q;

endmodule

// File: rtl/param_reg_file.sv
// NUM_REGS x WIDTH counter register file with two registered, write-through read ports.
// Out-of-range read indices return zero.
module param_reg_file
    import param_rf_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               NUM_REGS  = 8,
    parameter int               SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              SEL_W     = sel_w(NUM_REGS)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    I,
    input  logic [1:0]          fun_sel,
    input  logic [NUM_REGS-1:0] r_sel,
    input  logic [SEL_W-1:0]    o1_sel,
    input  logic [SEL_W-1:0]    o2_sel,
    input  logic                status_clr,
    output logic [WIDTH-1:0]    O1,
    output logic [WIDTH-1:0]    O2,
    output logic [NUM_REGS-1:0] wrap_flags
);

    localparam int NUM_SLOTS = 1 << SEL_W;

    logic [WIDTH-1:0] rd_val [NUM_SLOTS];
    logic [WIDTH-1:0] o1_q, o1_d, o2_q, o2_d;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        rf_cell #(
            .WIDTH     (WIDTH),
            .SATURATE  (SATURATE),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk          (clk),
            .rst_n        (rst_n),
            .en_i         (r_sel[k]),
            .fun_sel_i    (fun_sel),
            .data_i       (I),
            .status_clr_i (status_clr),
            .d_o          (rd_val[k]),
            .flag_o       (wrap_flags[k])
        );
    end

    for (genvar k = NUM_REGS; k < NUM_SLOTS; k++) begin : g_pad
        assign rd_val[k] = '0;
    end

    assign o1_d = rd_val[o1_sel];
    assign o2_d = rd_val[o2_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o1_q <= '0;
            o2_q <= '0;
        end else begin
            o1_q <= o1_d;
            o2_q <= o2_d;
        end
    end

    assign O1 = o1_q;
    assign O2 = o2_q;

endmodule
